fft_input_buffer: RTL and testbench

FFT_INPUT_BUFFER -- requirements
Module: fft_input_buffer

---
 rtl/fft_input_buffer.sv | 204 ++++++++++++++++++++
 tb/tb_fft_input_buffer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_input_buffer.sv
// fft_input_buffer: double-buffered (ping-pong) frame collector in front of a
// 16-point FFT. Samples stream in, are stored in bit-reversed word order, and a
// full bank is handed to the transform stage with a one-cycle fft_start pulse.
// The bank is held stable until the transform stage raises fft_done.
`timescale 1ns/1ps

module fft_input_buffer (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [15:0]  s_real,
    input  logic [15:0]  s_imag,
    input  logic         s_last,
    output logic [255:0] frame_real,
    output logic [255:0] frame_imag,
    output logic         fft_start,
    input  logic         fft_done,
    output logic         frame_bank,
    output logic         err_framing
);

    // Bank status encoding
    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_FILLING = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;

    // Read-side FSM encoding
    localparam logic [1:0] RD_IDLE  = 2'd0;
    localparam logic [1:0] RD_START = 2'd1;
    localparam logic [1:0] RD_WAIT  = 2'd2;

    // 4-bit bit reversal: sample i lands at word bitrev4(i) so the FFT can
    // consume the bank in natural order.
    function automatic logic [3:0] bitrev4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

    // Storage and state
    logic [15:0]  r_mem_real [0:1][0:15];
    logic [15:0]  r_mem_imag [0:1][0:15];
    logic [1:0]   r_bank_st  [0:1];
    logic [3:0]   r_wr_cnt;
    logic         r_wr_bank;
    logic         r_rd_bank;
    logic [1:0]   r_rd_state;
    logic         r_done_q;
    logic         r_fft_start;
    logic         r_err;
    logic [255:0] r_frame_real;
    logic [255:0] r_frame_imag;
    logic         r_frame_bank;

    // Combinational helpers
    logic         w_ready;
    logic         w_accept;
    logic         w_cnt_end;
    logic         w_short;
    logic         w_store;
    logic         w_done_rise;
    logic         w_release;
    logic [1:0]   w_rd_next;
    logic [255:0] w_sel_real;
    logic [255:0] w_sel_imag;

    // Ready is a function of registered bank state only; forced low in reset.
    assign w_ready     = (r_bank_st[r_wr_bank] != ST_FULL) && !rst;
    assign w_accept    = s_valid && w_ready;
    assign w_cnt_end   = (r_wr_cnt == 4'd15);
    assign w_short     = w_accept && s_last && !w_cnt_end;
    assign w_store     = w_accept && !w_short;
    // A level held high never retriggers: edge = live input high, last sample low.
    assign w_done_rise = fft_done && !r_done_q;
    assign w_release   = (r_rd_state == RD_WAIT) && w_done_rise;

    assign s_ready     = w_ready;
    assign fft_start   = r_fft_start;
    assign frame_real  = r_frame_real;
    assign frame_imag  = r_frame_imag;
    assign frame_bank  = r_frame_bank;
    assign err_framing = r_err;

    // Read FSM next-state: wait for a full bank, pulse start, wait for done edge.
    always_comb begin
        w_rd_next = r_rd_state;
        case (r_rd_state)
            RD_IDLE: begin
                if (r_bank_st[r_rd_bank] == ST_FULL) begin
                    w_rd_next = RD_START;
                end else begin
                    w_rd_next = RD_IDLE;
                end
            end
            RD_START: begin
                w_rd_next = RD_WAIT;
            end
            RD_WAIT: begin
                if (w_done_rise) begin
                    w_rd_next = RD_IDLE;
                end else begin
                    w_rd_next = RD_WAIT;
                end
            end
            default: begin
                w_rd_next = RD_IDLE;
            end
        endcase
    end

    // Select the read bank's words and pack them onto the wide frame buses.
    always_comb begin
        w_sel_real = 256'd0;
        w_sel_imag = 256'd0;
        for (int k = 0; k < 16; k++) begin
            w_sel_real[16*k +: 16] = r_mem_real[r_rd_bank][k];
            w_sel_imag[16*k +: 16] = r_mem_imag[r_rd_bank][k];
        end
    end

    // Write-side counter, bank pointer and sticky framing error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_cnt  <= 4'd0;
            r_wr_bank <= 1'b0;
            r_err     <= 1'b0;
        end else if (w_accept) begin
            if (w_cnt_end) begin
                r_wr_cnt  <= 4'd0;
                r_wr_bank <= ~r_wr_bank;
                if (!s_last) begin
                    r_err <= 1'b1;
                end
            end else if (s_last) begin
                // Short frame: drop it and restart the same bank.
                r_wr_cnt <= 4'd0;
                r_err    <= 1'b1;
            end else begin
                r_wr_cnt <= r_wr_cnt + 4'd1;
            end
        end
    end

    // Sample storage, written in bit-reversed word order.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < 16; k++) begin
                    r_mem_real[b][k] <= 16'd0;
                    r_mem_imag[b][k] <= 16'd0;
                end
            end
        end else if (w_store) begin
            r_mem_real[r_wr_bank][bitrev4(r_wr_cnt)] <= s_real;
            r_mem_imag[r_wr_bank][bitrev4(r_wr_cnt)] <= s_imag;
        end
    end

    // Bank status: writer drives EMPTY/FILLING/FULL, reader frees a FULL bank.
    // The writer can never target a FULL bank, so the two never collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bank_st[0] <= ST_EMPTY;
            r_bank_st[1] <= ST_EMPTY;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (w_accept && (r_wr_bank == 1'(b))) begin
                    if (w_cnt_end) begin
                        r_bank_st[b] <= ST_FULL;
                    end else if (s_last) begin
                        r_bank_st[b] <= ST_EMPTY;
                    end else begin
                        r_bank_st[b] <= ST_FILLING;
                    end
                end else if (w_release && (r_rd_bank == 1'(b))) begin
                    r_bank_st[b] <= ST_EMPTY;
                end
            end
        end
    end

    // Read FSM state, read pointer, done history, start pulse and frame outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_state   <= RD_IDLE;
            r_rd_bank    <= 1'b0;
            r_done_q     <= 1'b0;
            r_fft_start  <= 1'b0;
            r_frame_real <= 256'd0;
            r_frame_imag <= 256'd0;
            r_frame_bank <= 1'b0;
        end else begin
            r_rd_state   <= w_rd_next;
            r_done_q     <= fft_done;
            r_fft_start  <= (w_rd_next == RD_START);
            r_frame_real <= w_sel_real;
            r_frame_imag <= w_sel_imag;
            r_frame_bank <= r_rd_bank;
            if (w_release) begin
                r_rd_bank <= ~r_rd_bank;
            end
        end
    end

endmodule

// File: tb/tb_fft_input_buffer.sv
// Directed testbench for fft_input_buffer: ordering, latency, ping-pong,
// framing errors, held done level and reset behaviour.
`timescale 1ns/1ps

module tb_fft_input_buffer;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_valid;
    logic         s_ready;
    logic [15:0]  s_real;
    logic [15:0]  s_imag;
    logic         s_last;
    logic [255:0] frame_real;
    logic [255:0] frame_imag;
    logic         fft_start;
    logic         fft_done;
    logic         frame_bank;
    logic         err_framing;

    int total = 0;
    int bad   = 0;
    int start_cnt = 0;

    fft_input_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_real      (s_real),
        .s_imag      (s_imag),
        .s_last      (s_last),
        .frame_real  (frame_real),
        .frame_imag  (frame_imag),
        .fft_start   (fft_start),
        .fft_done    (fft_done),
        .frame_bank  (frame_bank),
        .err_framing (err_framing)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Count every cycle with fft_start high, sampled mid-cycle.
    always @(negedge clk) begin
        if (fft_start === 1'b1) start_cnt++;
    end

    function automatic logic [15:0] word(input logic [255:0] v, input int k);
        return v[16*k +: 16];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; fft_done = 1'b0;
        s_real = 16'd0; s_imag = 16'd0;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    // Offer one sample; returns the number of cycles spent waiting for ready.
    task automatic send(input logic [15:0] re, input logic [15:0] im,
                        input logic last, output int waited);
        s_valid = 1'b1; s_real = re; s_imag = im; s_last = last; waited = 0;
        while (s_ready !== 1'b1 && waited < 40) begin
            tick();
            waited++;
        end
        tick();
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic send_frame(input int base_re, input int base_im,
                              input bit with_last, output int stalls);
        int w;
        stalls = 0;
        for (int i = 0; i < 16; i++) begin
            send(16'(base_re + i), 16'(base_im + i), with_last && (i == 15), w);
            stalls += w;
        end
    endtask

    task automatic wait_start(input int limit, output bit seen);
        seen = 1'b0;
        for (int n = 0; n < limit; n++) begin
            tick();
            if (fft_start === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_done();
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; fft_done = 1'b0;
        s_real = 16'd0; s_imag = 16'd0;
        #1;
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL reset_ready actual=%0d required=0", s_ready); end
        tick();
        tick();
        total++; if (fft_start !== 1'b0) begin bad++; $display("FAIL reset_start actual=%0d required=0", fft_start); end
        total++; if (err_framing !== 1'b0) begin bad++; $display("FAIL reset_err actual=%0d required=0", err_framing); end
        total++; if (frame_bank !== 1'b0) begin bad++; $display("FAIL reset_bank actual=%0d required=0", frame_bank); end
        total++; if (frame_real !== 256'd0 || frame_imag !== 256'd0) begin bad++; $display("FAIL reset_frame actual=%0h/%0h required=0", frame_real, frame_imag); end
        rst = 1'b0;
        #1;
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready actual=%0d required=1", s_ready); end
    endtask

    task automatic test_ordering();
        int st; int s0;
        do_reset();
        s0 = start_cnt;
        send_frame(0, 100, 1'b1, st);
        total++; if (st !== 0) begin bad++; $display("FAIL order_stalls actual=%0d required=0", st); end
        total++; if (fft_start !== 1'b0) begin bad++; $display("FAIL order_latency_early actual=%0d required=0", fft_start); end
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL order_ready_other_bank actual=%0d required=1", s_ready); end
        tick();
        total++; if (fft_start !== 1'b1) begin bad++; $display("FAIL order_latency_start actual=%0d required=1", fft_start); end
        total++; if (word(frame_real, 8) !== 16'd1) begin bad++; $display("FAIL order_real_w8 actual=%0d required=1", word(frame_real, 8)); end
        total++; if (word(frame_real, 12) !== 16'd3) begin bad++; $display("FAIL order_real_w12 actual=%0d required=3", word(frame_real, 12)); end
        total++; if (word(frame_real, 15) !== 16'd15) begin bad++; $display("FAIL order_real_w15 actual=%0d required=15", word(frame_real, 15)); end
        total++; if (word(frame_real, 4) !== 16'd2) begin bad++; $display("FAIL order_real_w4 actual=%0d required=2", word(frame_real, 4)); end
        total++; if (word(frame_imag, 8) !== 16'd101) begin bad++; $display("FAIL order_imag_w8 actual=%0d required=101", word(frame_imag, 8)); end
        total++; if (frame_bank !== 1'b0) begin bad++; $display("FAIL order_bank actual=%0d required=0", frame_bank); end
        tick();
        total++; if (fft_start !== 1'b0) begin bad++; $display("FAIL order_pulse_width actual=%0d required=0", fft_start); end
        pulse_done();
        total++; if (start_cnt - s0 !== 1) begin bad++; $display("FAIL order_start_count actual=%0d required=1", start_cnt - s0); end
    endtask

    task automatic test_pingpong();
        int st1; int st2; int st3; int s0; bit seen;
        do_reset();
        s0 = start_cnt;
        send_frame(0, 300, 1'b1, st1);
        send_frame(16, 316, 1'b1, st2);
        total++; if (st1 + st2 !== 0) begin bad++; $display("FAIL pp_no_stall actual=%0d required=0", st1 + st2); end
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL pp_full_ready actual=%0d required=0", s_ready); end
        repeat (4) tick();
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL pp_full_ready_hold actual=%0d required=0", s_ready); end
        total++; if (start_cnt - s0 !== 1) begin bad++; $display("FAIL pp_one_start actual=%0d required=1", start_cnt - s0); end
        fft_done = 1'b1;
        tick();
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL pp_ready_rise actual=%0d required=1", s_ready); end
        wait_start(3, seen);
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL pp_start_bank1 actual=%0d required=1", seen); end
        total++; if (frame_bank !== 1'b1) begin bad++; $display("FAIL pp_bank1 actual=%0d required=1", frame_bank); end
        total++; if (word(frame_real, 8) !== 16'd17) begin bad++; $display("FAIL pp_bank1_w8 actual=%0d required=17", word(frame_real, 8)); end
        fft_done = 1'b0;
        send_frame(32, 332, 1'b1, st3);
        total++; if (st3 !== 0) begin bad++; $display("FAIL pp_third_no_stall actual=%0d required=0", st3); end
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL pp_third_full_ready actual=%0d required=0", s_ready); end
        total++; if (start_cnt - s0 !== 2) begin bad++; $display("FAIL pp_two_starts actual=%0d required=2", start_cnt - s0); end
        fft_done = 1'b1;
        tick();
        wait_start(3, seen);
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL pp_start_bank0 actual=%0d required=1", seen); end
        total++; if (frame_bank !== 1'b0) begin bad++; $display("FAIL pp_bank0 actual=%0d required=0", frame_bank); end
        total++; if (word(frame_real, 8) !== 16'd33) begin bad++; $display("FAIL pp_bank0_w8 actual=%0d required=33", word(frame_real, 8)); end
        fft_done = 1'b0;
        tick();
    endtask

    task automatic test_short_frame();
        int w; int st; int s0;
        do_reset();
        s0 = start_cnt;
        for (int i = 0; i < 5; i++) send(16'(i), 16'd0, i == 4, w);
        total++; if (err_framing !== 1'b1) begin bad++; $display("FAIL short_err actual=%0d required=1", err_framing); end
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL short_ready actual=%0d required=1", s_ready); end
        repeat (5) tick();
        total++; if (start_cnt - s0 !== 0) begin bad++; $display("FAIL short_no_start actual=%0d required=0", start_cnt - s0); end
        send_frame(50, 150, 1'b1, st);
        tick();
        total++; if (fft_start !== 1'b1) begin bad++; $display("FAIL short_next_start actual=%0d required=1", fft_start); end
        total++; if (frame_bank !== 1'b0) begin bad++; $display("FAIL short_next_bank actual=%0d required=0", frame_bank); end
        total++; if (word(frame_real, 0) !== 16'd50 || word(frame_real, 8) !== 16'd51) begin bad++; $display("FAIL short_next_data actual=%0d,%0d required=50,51", word(frame_real, 0), word(frame_real, 8)); end
        total++; if (err_framing !== 1'b1) begin bad++; $display("FAIL short_err_sticky actual=%0d required=1", err_framing); end
        pulse_done();
    endtask

    task automatic test_missing_last();
        int st;
        do_reset();
        send_frame(0, 0, 1'b0, st);
        total++; if (err_framing !== 1'b1) begin bad++; $display("FAIL nolast_err actual=%0d required=1", err_framing); end
        tick();
        total++; if (fft_start !== 1'b1) begin bad++; $display("FAIL nolast_start actual=%0d required=1", fft_start); end
        pulse_done();
    endtask

    task automatic test_held_done();
        int st; int s0;
        do_reset();
        s0 = start_cnt;
        send_frame(0, 0, 1'b1, st);
        send_frame(16, 16, 1'b1, st);
        fft_done = 1'b1;
        repeat (20) tick();
        total++; if (start_cnt - s0 !== 2) begin bad++; $display("FAIL held_start_count actual=%0d required=2", start_cnt - s0); end
        total++; if (frame_bank !== 1'b1) begin bad++; $display("FAIL held_single_release actual=%0d required=1", frame_bank); end
        fft_done = 1'b0;
        tick();
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL held_ready actual=%0d required=1", s_ready); end
        send_frame(32, 32, 1'b1, st);
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL held_refill_ready actual=%0d required=0", s_ready); end
        repeat (3) tick();
        total++; if (start_cnt - s0 !== 2) begin bad++; $display("FAIL held_no_extra_start actual=%0d required=2", start_cnt - s0); end
    endtask

    task automatic test_reset_mid();
        int w; int st; int s0; int s1;
        do_reset();
        s0 = start_cnt;
        for (int i = 0; i < 7; i++) send(16'(i), 16'(i), 1'b0, w);
        rst = 1'b1;
        #1;
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL mid_ready_in_reset actual=%0d required=0", s_ready); end
        tick();
        total++; if (fft_start !== 1'b0 || err_framing !== 1'b0 || frame_bank !== 1'b0) begin bad++; $display("FAIL mid_outputs actual=%0d%0d%0d required=000", fft_start, err_framing, frame_bank); end
        total++; if (frame_real !== 256'd0 || frame_imag !== 256'd0) begin bad++; $display("FAIL mid_frame_clear actual=%0h/%0h required=0", frame_real, frame_imag); end
        rst = 1'b0;
        #1;
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL mid_ready_after actual=%0d required=1", s_ready); end
        repeat (5) tick();
        total++; if (start_cnt - s0 !== 0) begin bad++; $display("FAIL mid_no_start actual=%0d required=0", start_cnt - s0); end
        send_frame(70, 170, 1'b1, st);
        tick();
        total++; if (fft_start !== 1'b1 || frame_bank !== 1'b0) begin bad++; $display("FAIL mid_fresh_start actual=%0d/%0d required=1/0", fft_start, frame_bank); end
        total++; if (word(frame_real, 8) !== 16'd71) begin bad++; $display("FAIL mid_fresh_w8 actual=%0d required=71", word(frame_real, 8)); end
        tick();
        send_frame(90, 190, 1'b1, st);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        s1 = start_cnt;
        repeat (6) tick();
        total++; if (start_cnt - s1 !== 0) begin bad++; $display("FAIL wait_reset_no_start actual=%0d required=0", start_cnt - s1); end
    endtask

    initial begin
        test_reset();
        test_ordering();
        test_pingpong();
        test_short_frame();
        test_missing_last();
        test_held_done();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound
    initial begin
        #500000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
